// File: rtl/alu_iq_dispatch_arb.sv
// ALU issue-queue dispatch arbiter.
// Maps dispatch slots onto issue queues and tracks free-entry credits.
module alu_iq_dispatch_arb #(
    parameter int NUM_IQ       = 2,
    parameter int IQ_SIZE      = 4,
    parameter int DISPATCH_CNT = 2,
    localparam int CW          = $clog2(IQ_SIZE) + 1,
    localparam int PW          = $clog2(NUM_IQ)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  other_ready,
    input  logic [DISPATCH_CNT-1:0]               slot_valid_i,
    input  logic [DISPATCH_CNT-1:0]               slot_is_alu_i,
    output logic [DISPATCH_CNT-1:0]               slot_ready_o,
    output logic [NUM_IQ-1:0][DISPATCH_CNT-1:0]   choose_o,
    input  logic [NUM_IQ-1:0]                     iq_issue_i,
    output logic [NUM_IQ-1:0][CW-1:0]             credit_o,
    output logic                                  credit_err_o
);

    localparam logic [CW-1:0] FULL = CW'(IQ_SIZE);
    localparam logic [PW-1:0] LAST = PW'(NUM_IQ - 1);

    logic [NUM_IQ-1:0][CW-1:0]  credit_q;
    logic [NUM_IQ-1:0][CW-1:0]  credit_d;
    logic [PW-1:0]              rr_ptr_q;
    logic [PW-1:0]              rr_ptr_d;
    logic                       err_q;
    logic                       err_set;

    logic [NUM_IQ-1:0]          avail;
    logic [NUM_IQ-1:0]          taken;
    logic [NUM_IQ-1:0]          gnt_q;
    logic                       lower_ok;
    logic                       found;
    logic                       any_gnt;
    logic [PW-1:0]              last_q;
    int                         qi;

    // In-order slot walk; each ALU slot takes the next free queue from rr_ptr
    always_comb begin
        choose_o     = '0;
        slot_ready_o = '0;
        taken        = '0;
        lower_ok     = 1'b1;
        found        = 1'b0;
        any_gnt      = 1'b0;
        last_q       = '0;
        qi           = 0;
        for (int q = 0; q < NUM_IQ; q++) begin
            avail[q] = (credit_q[q] != '0);
        end
        for (int s = 0; s < DISPATCH_CNT; s++) begin
            found = 1'b0;
            if (!slot_valid_i[s]) begin
                slot_ready_o[s] = lower_ok;
            end else if (!slot_is_alu_i[s]) begin
                slot_ready_o[s] = lower_ok & other_ready;
            end else if (lower_ok && other_ready && rst_n && !flush) begin
                for (int k = 0; k < NUM_IQ; k++) begin
                    qi = int'(rr_ptr_q) + k;
                    if (qi >= NUM_IQ) qi = qi - NUM_IQ;
                    if (!found && avail[qi] && !taken[qi]) begin
                        found          = 1'b1;
                        taken[qi]      = 1'b1;
                        choose_o[qi][s] = 1'b1;
                        last_q         = PW'(qi);
                        any_gnt        = 1'b1;
                    end
                end
                slot_ready_o[s] = found;
            end
            lower_ok = slot_ready_o[s];
        end
    end

    // Credit bookkeeping: grant consumes, issue returns, saturate at full
    always_comb begin
        credit_d = credit_q;
        err_set  = 1'b0;
        for (int q = 0; q < NUM_IQ; q++) begin
            gnt_q[q] = |choose_o[q];
            if (iq_issue_i[q] && !gnt_q[q]) begin
                if (credit_q[q] == FULL) err_set = 1'b1;
                else credit_d[q] = credit_q[q] + CW'(1);
            end else if (gnt_q[q] && !iq_issue_i[q]) begin
                credit_d[q] = credit_q[q] - CW'(1);
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (any_gnt) begin
            rr_ptr_d = (last_q == LAST) ? '0 : last_q + PW'(1);
        end
    end

    // State registers; reset and flush override every same-cycle event
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int q = 0; q < NUM_IQ; q++) credit_q[q] <= FULL;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_q | err_set;
        end
    end

    assign credit_o     = credit_q;
    assign credit_err_o = err_q;

endmodule

// File: tb/tb_alu_iq_dispatch_arb.sv
// Directed bench for alu_iq_dispatch_arb.
// NUM_IQ=2, IQ_SIZE=4, DISPATCH_CNT=2.
module tb_alu_iq_dispatch_arb;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             other_ready;
    logic [1:0]       slot_valid_i;
    logic [1:0]       slot_is_alu_i;
    logic [1:0]       slot_ready_o;
    logic [1:0][1:0]  choose_o;
    logic [1:0]       iq_issue_i;
    logic [1:0][2:0]  credit_o;
    logic             credit_err_o;

    int nvec;
    int nerr;

    alu_iq_dispatch_arb #(
        .NUM_IQ(2),
        .IQ_SIZE(4),
        .DISPATCH_CNT(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .other_ready(other_ready),
        .slot_valid_i(slot_valid_i),
        .slot_is_alu_i(slot_is_alu_i),
        .slot_ready_o(slot_ready_o),
        .choose_o(choose_o),
        .iq_issue_i(iq_issue_i),
        .credit_o(credit_o),
        .credit_err_o(credit_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] a,
                         input logic orr, input logic [1:0] iss,
                         input logic fl);
        slot_valid_i  = v;
        slot_is_alu_i = a;
        other_ready   = orr;
        iq_issue_i    = iss;
        flush         = fl;
        #1;
    endtask

    // credit packing helper: {c1, c0}
    function automatic logic [31:0] cr(input int c1, input int c0);
        logic [5:0] p;
        p = {3'(c1), 3'(c0)};
        return 32'(p);
    endfunction

    initial begin
        nvec  = 0;
        nerr  = 0;
        rst_n = 1'b0;
        drive(2'b11, 2'b11, 1'b1, 2'b00, 1'b0);
        check("choose_in_reset", 32'(choose_o), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_credit", cr(credit_o[1], credit_o[0]), cr(4, 4));
        check("reset_err", 32'(credit_err_o), 32'h0);

        // dual ALU dispatch
        drive(2'b11, 2'b11, 1'b1, 2'b00, 1'b0);
        check("dual_choose", 32'(choose_o), 32'b1001);
        check("dual_ready", 32'(slot_ready_o), 32'b11);
        tick();
        check("dual_credit", cr(credit_o[1], credit_o[0]), cr(3, 3));

        // fill to zero
        for (int i = 0; i < 3; i++) begin
            check("fill_choose", 32'(choose_o), 32'b1001);
            tick();
        end
        check("fill_credit", cr(credit_o[1], credit_o[0]), cr(0, 0));
        drive(2'b11, 2'b11, 1'b1, 2'b10, 1'b0);
        check("empty_ready", 32'(slot_ready_o), 32'b00);
        check("empty_choose", 32'(choose_o), 32'h0);
        tick();
        drive(2'b11, 2'b11, 1'b1, 2'b00, 1'b0);
        check("ret_choose", 32'(choose_o), 32'b0100);
        check("ret_ready", 32'(slot_ready_o), 32'b01);
        tick();
        check("ret_credit", cr(credit_o[1], credit_o[0]), cr(0, 0));

        // build credit {0,2}
        drive(2'b00, 2'b00, 1'b1, 2'b10, 1'b0);
        tick();
        tick();
        check("io_credit", cr(credit_o[1], credit_o[0]), cr(2, 0));
        drive(2'b11, 2'b10, 1'b1, 2'b00, 1'b0);
        check("io_ready", 32'(slot_ready_o), 32'b11);
        check("io_choose", 32'(choose_o), 32'b1000);
        drive(2'b11, 2'b10, 1'b0, 2'b00, 1'b0);
        check("nordy_ready", 32'(slot_ready_o), 32'b00);
        check("nordy_choose", 32'(choose_o), 32'h0);
        tick();
        check("nordy_credit", cr(credit_o[1], credit_o[0]), cr(2, 0));

        // build credit {1,0}
        drive(2'b11, 2'b11, 1'b1, 2'b00, 1'b0);
        check("b1_choose", 32'(choose_o), 32'b0100);
        check("b1_ready", 32'(slot_ready_o), 32'b01);
        tick();
        drive(2'b11, 2'b11, 1'b1, 2'b01, 1'b0);
        check("b2_choose", 32'(choose_o), 32'b0100);
        tick();
        check("blk_credit0", cr(credit_o[1], credit_o[0]), cr(0, 1));

        // blocking
        drive(2'b11, 2'b11, 1'b1, 2'b00, 1'b0);
        check("blk_choose", 32'(choose_o), 32'b0001);
        check("blk_ready", 32'(slot_ready_o), 32'b01);
        tick();
        check("blk_credit", cr(credit_o[1], credit_o[0]), cr(0, 0));
        check("replay_ready", 32'(slot_ready_o), 32'b00);
        check("replay_choose", 32'(choose_o), 32'h0);

        // simultaneous grant and issue on q0 at credit 2
        drive(2'b00, 2'b00, 1'b1, 2'b01, 1'b0);
        tick();
        tick();
        check("sim_pre", cr(credit_o[1], credit_o[0]), cr(0, 2));
        drive(2'b01, 2'b01, 1'b1, 2'b01, 1'b0);
        check("sim_choose", 32'(choose_o), 32'b0001);
        tick();
        check("sim_credit", cr(credit_o[1], credit_o[0]), cr(0, 2));

        // q1 up to full, then one extra return
        drive(2'b00, 2'b00, 1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("full_credit", cr(credit_o[1], credit_o[0]), cr(4, 2));
        check("full_err", 32'(credit_err_o), 32'h0);
        tick();
        check("sat_credit", cr(credit_o[1], credit_o[0]), cr(4, 2));
        check("sat_err", 32'(credit_err_o), 32'h1);
        drive(2'b00, 2'b00, 1'b1, 2'b00, 1'b0);
        tick();
        check("sticky_err", 32'(credit_err_o), 32'h1);

        // rr_ptr is 1: slot0 -> q1, slot1 -> q0
        drive(2'b11, 2'b11, 1'b1, 2'b00, 1'b0);
        check("rr_choose", 32'(choose_o), 32'b0110);
        tick();
        check("pre_flush", cr(credit_o[1], credit_o[0]), cr(3, 1));

        // flush with in-flight returns
        drive(2'b11, 2'b11, 1'b1, 2'b11, 1'b1);
        check("flush_choose", 32'(choose_o), 32'h0);
        tick();
        drive(2'b11, 2'b11, 1'b1, 2'b00, 1'b0);
        check("flush_credit", cr(credit_o[1], credit_o[0]), cr(4, 4));
        check("flush_err", 32'(credit_err_o), 32'h0);
        check("flush_rr", 32'(choose_o), 32'b1001);
        tick();
        check("post_credit", cr(credit_o[1], credit_o[0]), cr(3, 3));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_iq_dispatch_arb.md
Name: alu_iq_dispatch_arb

Overview:
Dispatch-side scheduler that shares NUM_IQ ALU issue queues between DISPATCH_CNT dispatch slots. It produces each queue's per-slot choose vector, enforces in-order dispatch across slots, and keeps a per-queue credit counter of free entries. Credits are consumed on grant and returned on issue. It sits between rename/dispatch and the alu_iq instances, replacing per-queue entry_ready_o polling with exact credit tracking.

Parameters:
NUM_IQ, 2, number of ALU issue queues arbitrated (>=2)
IQ_SIZE, 4, entries per queue; initial and maximum credit
DISPATCH_CNT, 2, dispatch slots per cycle

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
flush  in  1  pipeline flush; synchronous, same effect as reset on state
other_ready  in  1  downstream resources (ROB etc.) can accept this cycle; gates all grants
slot_valid_i  in  DISPATCH_CNT  slot holds a valid instruction
slot_is_alu_i  in  DISPATCH_CNT  slot instruction targets an ALU queue
slot_ready_o  out  DISPATCH_CNT  slot may fire this cycle (combinational)
choose_o  out  NUM_IQ x DISPATCH_CNT  choose_o[q][s]=1: slot s written into queue q this cycle
iq_issue_i  in  NUM_IQ  queue q freed one entry this cycle (issue handshake completed)
credit_o  out  NUM_IQ x (clog2(IQ_SIZE)+1)  registered credit per queue
credit_err_o  out  1  sticky: issue return while credit already IQ_SIZE

Behaviour:
- State: credit_q[q] (width clog2(IQ_SIZE)+1), rr_ptr_q (clog2(NUM_IQ)), err_q.
- Reset or flush: credit_q[q]=IQ_SIZE for all q, rr_ptr_q=0, err_q=0. Reset and flush take priority over every same-cycle event. credit_o reset value = IQ_SIZE. credit_err_o reset value = 0.
- avail[q] = (credit_q[q] != 0). Uses registered credit only: a same-cycle iq_issue_i does not make a queue available until the next cycle.
- Grant search, slots in ascending order, each queue at most once per cycle (each queue accepts one instruction per cycle):
  - Slot s requests iff slot_valid_i[s] & slot_is_alu_i[s] & other_ready, and every lower slot is ready (in-order).
  - A requesting slot takes the first avail, not-yet-granted queue scanning q = rr_ptr_q, rr_ptr_q+1, ... modulo NUM_IQ.
- slot_ready_o[s]:
  - ALU slot: 1 iff granted.
  - Non-ALU slot: 1 iff other_ready and all lower slots are ready.
  - Invalid slot: 1 iff all lower slots are ready.
  - Once a slot is not ready, all higher slots are 0.
- choose_o is one-hot or zero per queue and per slot. It is combinational from the inputs and registered state (zero latency). It is all-zero when rst_n=0 or flush=1.
- Credit update: credit_q[q] <= credit_q[q] - (|choose_o[q]) + iq_issue_i[q].
  - Simultaneous grant and issue leaves the credit unchanged.
  - An issue with credit_q[q]==IQ_SIZE and no grant is ignored (saturate) and sets err_q.
  - A grant never occurs at credit 0, so there is no underflow.
- rr_ptr_q <= (index of highest-numbered slot's granted queue)+1 mod NUM_IQ when any grant occurs; otherwise it holds.
- flush mid-operation: in-flight issue returns in the flush cycle are discarded (credits reload to IQ_SIZE).

Test Plan:
- Reset, NUM_IQ=2, IQ_SIZE=4 -> credit_o={4,4}, choose_o=0. Then both slots valid ALU, other_ready=1 -> choose_o[0]=01, choose_o[1]=10, slot_ready_o=11, next cycle credit={3,3}, rr_ptr=0.
- Fill: repeat dual ALU dispatch 4 cycles with no issue -> credits reach {0,0}, next cycle slot_ready_o=00, choose_o=0. Same-cycle iq_issue_i[1] -> grant to q1 only on the following cycle.
- In-order: credit={0,2}, slot0 non-ALU valid, slot1 ALU -> slot_ready_o=11, choose_o[1]=10. With other_ready=0 -> slot_ready_o=00 for valid slots.
- Blocking: credit={1,0}, both slots ALU -> slot0 to q0, slot1 not ready. Next cycle slot0 (replayed) ready=0, credit={0,0}.
- Simultaneous grant+issue on q0 at credit 2 -> credit stays 2. Issue on q1 at credit 4 -> credit stays 4, credit_err_o=1 and stays 1 until flush.
- Flush while credit={1,3} and iq_issue_i=11 -> next cycle credit={4,4}, rr_ptr=0, credit_err_o=0.
